julia_dispatch: RTL and testbench

Frame-level work scheduler for the Julia pixel engines. It walks a WIDTH×HEIGHT frame in row-major order and hands each pixel coordinate and its framebuffer address to an idle engine. Engines are chosen by round-robin. The block tracks outstanding jobs via the per-engine retire pulses from the memory write controller, and signals frame completion once every dispatched pixel has been written back.

---
 rtl/julia_pkg.sv | 19 +
 rtl/julia_rr_arb.sv | 31 +++
 rtl/julia_dispatch.sv | 148 ++++++++++++++
 tb/tb_julia_dispatch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia frame dispatcher and its arbiter.
package julia_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_t;

    localparam int COORD_W     = 16;
    localparam int PIXEL_BYTES = 4;

    // Pointer/index width; a single engine still needs a 1-bit index.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/julia_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module julia_rr_arb
    import julia_pkg::*;
#(
    parameter int NUM_JULIA = 4,
    parameter int PTR_W     = ptr_width(NUM_JULIA)
) (
    input  logic [NUM_JULIA-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_JULIA-1:0] grant,
    output logic [PTR_W-1:0]     grant_idx,
    output logic                 any_grant
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_JULIA; k++) begin
            idx = (int'(ptr) + k) % NUM_JULIA;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/julia_dispatch.sv
// Frame scheduler: walks the frame row-major and hands pixels to idle engines.
// Optional JULIA_DISPATCH_PERF_EN adds frame_cycles / stall_cycles counters.
module julia_dispatch
    import julia_pkg::*;
#(
    parameter int NUM_JULIA = 4,
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_frame,
    input  logic                 abort,
    input  logic [31:0]          frame_base,
    input  logic [NUM_JULIA-1:0] retire,
    output logic [NUM_JULIA-1:0] start,
    output logic [COORD_W-1:0]   job_x,
    output logic [COORD_W-1:0]   job_y,
    output logic [31:0]          job_addr,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 aborted
`ifdef JULIA_DISPATCH_PERF_EN
    ,
    output logic [31:0]          frame_cycles,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int                 PTR_W  = ptr_width(NUM_JULIA);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    disp_state_t          state, state_nxt;
    logic [COORD_W-1:0]   x_ctr, y_ctr;
    logic [31:0]          addr_ctr;
    logic [NUM_JULIA-1:0] busy, idle, grant;
    logic [PTR_W-1:0]     rr_ptr, grant_idx;
    logic                 any_grant, dispatch, last_pixel, frame_accept;

    // Eligibility comes from the registered busy vector only, so a retire
    // frees its engine for the following cycle.
    assign idle = ~busy;

    julia_rr_arb #(
        .NUM_JULIA (NUM_JULIA),
        .PTR_W     (PTR_W)
    ) u_arb (
        .req       (idle),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign frame_accept = (state == ST_IDLE) && start_frame;
    assign dispatch     = (state == ST_RUN) && !abort && any_grant;
    assign last_pixel   = (x_ctr == X_LAST) && (y_ctr == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_busy = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_frame) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                frame_busy = 1'b1;
                if (abort || (dispatch && last_pixel)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                frame_busy = 1'b1;
                if (busy == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_ctr    <= '0;
            y_ctr    <= '0;
            addr_ctr <= '0;
            busy     <= '0;
            rr_ptr   <= '0;
            start    <= '0;
            job_x    <= '0;
            job_y    <= '0;
            job_addr <= '0;
            aborted  <= 1'b0;
        end else begin
            start <= '0;
            if (frame_accept) begin
                x_ctr    <= '0;
                y_ctr    <= '0;
                addr_ctr <= frame_base;
                busy     <= '0;
                aborted  <= 1'b0;
            end else begin
                // Retire on an idle engine is a no-op; a granted engine is
                // never busy, so its own retire bit cannot cancel the grant.
                busy <= (busy & ~retire) | (dispatch ? grant : '0);
                if ((state == ST_RUN) && abort) aborted <= 1'b1;
                if (dispatch) begin
                    start    <= grant;
                    job_x    <= x_ctr;
                    job_y    <= y_ctr;
                    job_addr <= addr_ctr;
                    addr_ctr <= addr_ctr + 32'(PIXEL_BYTES);
                    if (x_ctr == X_LAST) begin
                        x_ctr <= '0;
                        y_ctr <= y_ctr + 1'b1;
                    end else begin
                        x_ctr <= x_ctr + 1'b1;
                    end
                    rr_ptr <= (int'(grant_idx) == NUM_JULIA - 1) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

`ifdef JULIA_DISPATCH_PERF_EN
    // Counters freeze once the frame leaves RUN/DRAIN and hold until restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else if (frame_accept) begin
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else begin
            if (frame_busy) frame_cycles <= frame_cycles + 32'd1;
            if ((state == ST_RUN) && (busy == '1)) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_julia_dispatch.sv
// Randomised self-checking bench for julia_dispatch against a pixel-index model.
module tb_julia_dispatch;

    localparam int N = 4;
    localparam int W = 4;
    localparam int H = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_frame = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   frame_base = '0;
    logic [N-1:0]  retire = '0;
    logic [N-1:0]  start;
    logic [15:0]   job_x, job_y;
    logic [31:0]   job_addr;
    logic          frame_busy, frame_done, aborted;
`ifdef JULIA_DISPATCH_PERF_EN
    logic [31:0]   frame_cycles, stall_cycles;
`endif

    julia_dispatch #(.NUM_JULIA(N), .WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_frame (start_frame),
        .abort       (abort),
        .frame_base  (frame_base),
        .retire      (retire),
        .start       (start),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_addr    (job_addr),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .aborted     (aborted)
`ifdef JULIA_DISPATCH_PERF_EN
        ,
        .frame_cycles(frame_cycles),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // stimulus requests, consumed by tick()
    logic          sf_req = 0, ab_req = 0, rst_req = 0;
    logic [31:0]   fb_req = '0;
    logic [N-1:0]  manual_ret = '0, spurious = '0;
    logic          auto_ret = 1'b1;
    int            ret_delay = 3;   // 0 = random 1..6

    // model: phase 0 idle, 1 run, 2 drain, 3 done; pixel index m_n
    int            m_ph = 0, m_n = 0, m_ptr = 0;
    logic [N-1:0]  m_busy = '0;
    logic [31:0]   m_base = '0;
    int            cnt [N];
    logic [N-1:0]  e_start = '0;
    logic [15:0]   e_jx = '0, e_jy = '0;
    logic [31:0]   e_addr = '0;
    logic          e_ab = 1'b0, e_done = 1'b0, e_fb = 1'b0;

    int            dut_starts = 0, dut_dones = 0;
    logic          last_ab = 1'b0;

    task automatic model_step(input logic rs, input logic sf, input logic ab,
                              input logic [31:0] fb, input logic [N-1:0] r);
        logic [N-1:0] nb;
        int g, idx;
        if (rs) begin
            m_ph = 0; m_n = 0; m_ptr = 0; m_busy = '0;
            e_start = '0; e_jx = '0; e_jy = '0; e_addr = '0; e_ab = 1'b0;
            for (int e = 0; e < N; e++) cnt[e] = 0;
        end else begin
            e_start = '0;
            nb = m_busy & ~r;
            case (m_ph)
                0: if (sf) begin m_ph = 1; m_n = 0; nb = '0; e_ab = 1'b0; m_base = fb; end
                1: begin
                    if (ab) begin
                        m_ph = 2; e_ab = 1'b1;
                    end else begin
                        g = -1;
                        for (int k = 0; k < N; k++) begin
                            idx = (m_ptr + k) % N;
                            if (g < 0 && !m_busy[idx]) g = idx;
                        end
                        if (g >= 0) begin
                            e_start[g] = 1'b1;
                            e_jx   = 16'(m_n % W);
                            e_jy   = 16'(m_n / W);
                            e_addr = m_base + 32'(m_n * 4);
                            nb[g]  = 1'b1;
                            m_ptr  = (g + 1) % N;
                            cnt[g] = (ret_delay > 0) ? ret_delay : int'($urandom_range(1, 6));
                            m_n++;
                            if (m_n == W * H) m_ph = 2;
                        end
                    end
                end
                2: if (m_busy == '0) m_ph = 3;
                default: m_ph = 0;
            endcase
            m_busy = nb;
        end
        e_done = (m_ph == 3);
        e_fb   = (m_ph == 1) || (m_ph == 2);
    endtask

    task automatic tick();
        logic [N-1:0] r;
        r = manual_ret;
        for (int e = 0; e < N; e++) begin
            if (cnt[e] > 0) cnt[e]--;
            if (auto_ret && m_busy[e] && cnt[e] == 0) r[e] = 1'b1;
        end
        r = r | (spurious & ~m_busy);
        rst = rst_req; start_frame = sf_req; abort = ab_req; frame_base = fb_req; retire = r;
        @(posedge clk);
        model_step(rst_req, sf_req, ab_req, fb_req, r);
        #1;
        chk("start", start, e_start);
        chk("frame_busy", frame_busy, e_fb);
        chk("frame_done", frame_done, e_done);
        chk("job_x", job_x, e_jx);
        chk("job_y", job_y, e_jy);
        chk("job_addr", job_addr, e_addr);
        if (e_done) chk("aborted", aborted, e_ab);
        if (start != '0) dut_starts++;
        if (frame_done) begin dut_dones++; last_ab = aborted; end
        sf_req = 0; ab_req = 0; rst_req = 0; manual_ret = '0; spurious = '0;
    endtask

    task automatic begin_frame(input logic [31:0] base);
        dut_starts = 0; dut_dones = 0;
        fb_req = base; sf_req = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int max);
        int i;
        i = 0;
        while (!e_done && i < max) begin tick(); i++; end
        if (!e_done) chk({tag, "_timeout"}, 64'd0, 64'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int e = 0; e < N; e++) cnt[e] = 0;
        rst_req = 1'b1; tick();
        rst_req = 1'b1; tick();
        chk("rst_busy", frame_busy, 1'b0);
        chk("rst_aborted", aborted, 1'b0);

        // nominal frame, fixed 3-cycle retire
        auto_ret = 1'b1; ret_delay = 3;
        begin_frame(32'h1000);
        wait_done("t1", 100);
        chk("t1_starts", dut_starts, 8);
        chk("t1_dones", dut_dones, 1);
        chk("t1_aborted", last_ab, 1'b0);

        // stall with no retires, then release engine 2 alone
        auto_ret = 1'b0;
        begin_frame(32'h2000);
        repeat (10) tick();
        chk("t2_stall_starts", dut_starts, 4);
        chk("t2_stall_busy", frame_busy, 1'b1);
        manual_ret = 4'b0100; tick();
        tick();
        chk("t2_eng", start, 4'b0100);
        chk("t2_x", job_x, 0);
        chk("t2_y", job_y, 1);
        chk("t2_addr", job_addr, 32'h2010);
        auto_ret = 1'b1;
        wait_done("t2", 100);
        chk("t2_starts", dut_starts, 8);

        // abort after three dispatches
        begin_frame(32'h4000);
        for (int i = 0; i < 20 && m_n < 3; i++) tick();
        ab_req = 1'b1; tick();
        wait_done("t3", 100);
        chk("t3_starts", dut_starts, 3);
        chk("t3_aborted", last_ab, 1'b1);

        // address wrap, restarting from (0,0)
        begin_frame(32'hFFFF_FFF8);
        tick();
        chk("t4_x0", job_x, 0);
        chk("t4_y0", job_y, 0);
        chk("t4_a0", job_addr, 32'hFFFF_FFF8);
        wait_done("t4", 100);
        chk("t4_starts", dut_starts, 8);

        // start_frame during RUN is ignored, spurious retires on idle engines
        begin_frame(32'h3000);
        tick(); tick();
        sf_req = 1'b1; fb_req = 32'hDEAD_0000; tick();
        for (int i = 0; i < 100 && !e_done; i++) begin spurious = N'($urandom); tick(); end
        wait_done("t5", 10);
        chk("t5_starts", dut_starts, 8);

        // random frames: random bases, delays, spurious retires, aborts
        ret_delay = 0;
        for (int f = 0; f < 8; f++) begin
            begin_frame($urandom);
            for (int i = 0; i < 300 && !e_done; i++) begin
                spurious = N'($urandom);
                ab_req   = ($urandom_range(0, 24) == 0);
                if (m_ph != 0) sf_req = ($urandom_range(0, 9) == 0);
                fb_req   = $urandom;
                tick();
            end
            wait_done("t6", 10);
            chk("t6_dones", dut_dones, 1);
        end

        // reset mid-frame
        ret_delay = 3;
        begin_frame(32'h5000);
        tick(); tick();
        rst_req = 1'b1; tick();
        chk("t7_start", start, '0);
        chk("t7_busy", frame_busy, 1'b0);
        chk("t7_addr", job_addr, 32'h0);
        chk("t7_aborted", aborted, 1'b0);
        tick();
        chk("t7_idle", frame_busy, 1'b0);
        begin_frame(32'h6000);
        wait_done("t7", 100);
        chk("t7_starts", dut_starts, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
